// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit: reset vector default, fetch FSM
// state encoding and next-PC select codes.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      STOP  = 2'd3
   } fetch_state_e;

   typedef enum logic [1:0] {
      SEQ = 2'd0,
      REL = 2'd1,
      REG = 2'd2
   } npc_sel_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC generator: sequential, pc-relative or register jump,
// with a flag for a target that is not word aligned.
module pc_next
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_val,
   input  logic [1:0]  select,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   always_comb begin
      next_pc = pc + 32'd4;
      case (select)
         REL:     next_pc = pc + imm;
         // Register jumps clear bit 0; bit 1 can still leave the target misaligned.
         REG:     next_pc = (rs1_val + imm) & ~32'd1;
         default: next_pc = pc + 32'd4;
      endcase
      misaligned = |next_pc[1:0];
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: request/response fetch from instruction memory,
// holds each instruction until retired, then redirects or stops.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ack,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic        halt,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_val,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic        misalign,
   output logic [31:0] retired,
   output logic [1:0]  state_dbg
);

   // Handshake: a request transfers on a cycle with imem_req_valid && imem_req_ready;
   // a response is taken only in WAIT; instr transfers on instr_valid && instr_ack.

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  retired_q, retired_d;
   logic         halted_q, halted_d;
   logic         misalign_q, misalign_d;

   logic [1:0]   npc_sel;
   logic [31:0]  next_pc;
   logic         next_misaligned;

   always_comb begin
      npc_sel = SEQ;
      if (jump_reg)
         npc_sel = REG;
      else if (jump || branch_taken)
         npc_sel = REL;
   end

   pc_next u_pc_next (
      .pc         (pc_q),
      .imm        (imm),
      .rs1_val    (rs1_val),
      .select     (npc_sel),
      .next_pc    (next_pc),
      .misaligned (next_misaligned)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      retired_d  = retired_q;
      halted_d   = halted_q;
      misalign_d = misalign_q;
      case (state_q)
         FETCH: if (imem_req_ready) state_d = WAIT;
         WAIT: begin
            if (imem_resp_valid) begin
               instr_d = imem_resp_data;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (instr_ack) begin
               retired_d = retired_q + 32'd1;
               // A halting instruction keeps its own address in pc.
               if (halt) begin
                  halted_d = 1'b1;
                  state_d  = STOP;
               end else begin
                  pc_d = next_pc;
                  if (next_misaligned) begin
                     misalign_d = 1'b1;
                     state_d    = STOP;
                  end else begin
                     state_d = FETCH;
                  end
               end
            end
         end
         default: state_d = STOP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         retired_q  <= 32'd0;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         retired_q  <= retired_d;
         halted_q   <= halted_d;
         misalign_q <= misalign_d;
      end
   end

   // Gated by rst_n so no request is seen while reset is held.
   assign imem_req_valid = rst_n && (state_q == FETCH);
   assign imem_req_addr  = pc_q;
   assign instr          = instr_q;
   assign instr_valid    = (state_q == HOLD);
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign halted         = halted_q;
   assign misalign       = misalign_q;
   assign retired        = retired_q;
   assign state_dbg      = state_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_req_addr  output  32  fetch address, equal to pc.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port imem_resp_valid  input  1  instruction word returned.
REQ-008 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-009 SHALL have port instr  output  32  held instruction for the decode/control stage.
REQ-010 SHALL have port instr_valid  output  1  instr is valid and awaiting retirement.
REQ-011 SHALL have port instr_ack  input  1  downstream retires instr this cycle; the redirect inputs below are sampled with it.
REQ-012 SHALL have ports branch_taken, jump, jump_reg, halt  input  1 each  per-instruction control decisions.
REQ-013 SHALL have port imm  input  32  sign-extended immediate of the current instruction.
REQ-014 SHALL have port rs1_val  input  32  rs1 value for register jumps.
REQ-015 SHALL have ports pc, pc_plus4  output  32 each  address of instr and its link value.
REQ-016 SHALL have port halted  output  1  fetch stopped by halt.
REQ-017 SHALL have port misalign  output  1  fetch stopped by a misaligned target.
REQ-018 SHALL have port retired  output  32  count of acknowledged instructions.

Function
REQ-019 SHALL implement the states FETCH, WAIT, HOLD, STOP.
REQ-020 FETCH: imem_req_valid=1 and imem_req_addr=pc; on req_ready the block SHALL move to WAIT.
REQ-021 WAIT: imem_req_valid=0; on imem_resp_valid the block SHALL latch imem_resp_data into instr and move to HOLD.
REQ-022 HOLD: instr_valid=1 and instr stays stable until instr_ack.
REQ-023 On instr_ack in HOLD, the block SHALL load pc with next_pc, increment retired, and move to FETCH, or to STOP if halt=1 or a misalign is detected.
REQ-024 next_pc priority SHALL be: jump_reg gives (rs1_val+imm)&~1; else jump or branch_taken gives pc+imm; else pc+4.
REQ-025 All adds SHALL be 32-bit modulo; pc+4 from 32'hFFFF_FFFC SHALL wrap to 0, and retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-026 If next_pc[1:0]!=0, pc SHALL be loaded with next_pc, misalign SHALL be set to 1, and the state SHALL go to STOP.
REQ-027 halt with instr_ack SHALL set halted=1; the halting instruction SHALL count in retired, and pc SHALL hold the halting instruction's address.
REQ-028 STOP SHALL issue no requests, keep instr_valid=0, and be left only by reset.
REQ-029 imem_resp_valid outside WAIT SHALL be ignored, with no state change.
REQ-030 A response SHALL NOT be accepted in the same cycle as the request; minimum per-instruction latency is 3 cycles (FETCH→WAIT→HOLD with zero wait states).
REQ-031 instr_ack outside HOLD SHALL be ignored.
REQ-032 pc_plus4 SHALL equal pc+4 combinationally at all times.

Reset
REQ-033 On rst_n=0, the block SHALL immediately set state=FETCH, pc=RESET_PC, instr=0, retired=0, instr_valid=0, halted=0, misalign=0.
REQ-034 Reset mid-WAIT or mid-HOLD SHALL abandon the in-flight fetch; a stale response arriving after reset before the new accept SHALL be ignored (see REQ-029).
REQ-035 imem_req_valid SHALL be 0 while rst_n=0 and SHALL rise in the first cycle after deassertion.

Structure
REQ-036 A shared package cpu_pkg SHALL hold RESET_PC default, the fetch state encoding, and the next-PC select codes (SEQ, REL, REG).
REQ-037 Next-PC computation SHALL be a combinational sub-module pc_next (inputs pc, imm, rs1_val, select; outputs next_pc, misaligned).

Verification
REQ-038 Reset with RESET_PC=0 and zero-wait memory returning 32'h00000013 → first request at address 0, instr_valid in the 3rd cycle after reset release, pc sequence 0,4,8 over three acks.
REQ-039 Ack with branch_taken=1, imm=-8 at pc=16 → next request address 8; retired increments by 1.
REQ-040 Ack with jump_reg=1 and jump=1, rs1_val=0x101, imm=0x20 → next address 0x120 (jump_reg wins, bit0 cleared).
REQ-041 Ack with jump=1, imm=6 at pc=0 → misalign=1, pc=6, no further imem_req_valid.
REQ-042 Ack with halt=1 at pc=0x40 → halted=1, pc=0x40, no requests for 100 cycles; rst_n pulse → fetch resumes at RESET_PC.
REQ-043 rst_n asserted in WAIT followed by a stale resp_valid two cycles after release → response ignored; instr reflects only the response to the new request.
